wb_arbiter: RTL and testbench

- Writeback arbiter directly upstream of the regfile.
- Merges two result sources onto the regfile's single write port:
  - ALU: single-cycle, high priority.
  - Memory/multi-cycle unit: buffered in a small FIFO.
- Drives write_addr/write_data/write_enable from registers, one write per cycle.
- A starvation counter guarantees forward progress for the FIFO under continuous ALU traffic.

---
 rtl/wb_arbiter.sv | 132 +++++++++++++
 tb/tb_wb_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - regfile writeback arbiter: ALU priority, FIFO-buffered mem results, starvation guard (option macro WB_R0_FILTER_EN)
module wb_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        alu_valid,
   output logic                        alu_ready,
   input  logic [ADDR_W-1:0]           alu_addr,
   input  logic [DATA_W-1:0]           alu_data,
   input  logic                        mem_valid,
   output logic                        mem_ready,
   input  logic [ADDR_W-1:0]           mem_addr,
   input  logic [DATA_W-1:0]           mem_data,
   output logic [ADDR_W-1:0]           write_addr,
   output logic [DATA_W-1:0]           write_data,
   output logic                        write_enable,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SC_W  = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [SC_W-1:0]  SMAX_C  = SC_W'(STARVE_MAX);

   typedef enum logic [1:0] {GRANT_NONE, GRANT_ALU, GRANT_MEM} grant_e;

   logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [SC_W-1:0]   starve_cnt;
   logic [SC_W-1:0]   starve_next;
   logic              force_mem;
   logic              fifo_ne;
   logic              alu_take;
   logic              push;
   logic              pop;
   grant_e            grant;

   assign fifo_count = count;
   assign fifo_ne    = (count != '0);
   // A full FIFO refuses a push even when it pops the same cycle.
   assign mem_ready  = (count < DEPTH_C);
   assign alu_ready  = !force_mem;

`ifdef WB_R0_FILTER_EN
   // Results for r0 complete their handshake but are silently dropped.
   assign alu_take = alu_valid && alu_ready && (alu_addr != '0);
   assign push     = mem_valid && mem_ready && (mem_addr != '0);
`else
   assign alu_take = alu_valid && alu_ready;
   assign push     = mem_valid && mem_ready;
`endif

   // Pick this cycle's writer and the next starvation count.
   always_comb begin
      grant       = GRANT_NONE;
      starve_next = '0;
      if (force_mem && fifo_ne) begin
         grant = GRANT_MEM;
      end else if (alu_take) begin
         grant = GRANT_ALU;
         if (fifo_ne) begin
            starve_next = (starve_cnt == SMAX_C) ? SMAX_C : starve_cnt + 1'b1;
         end
      end else if (fifo_ne) begin
         grant = GRANT_MEM;
      end
   end

   assign pop = (grant == GRANT_MEM);

   // FIFO payload storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= mem_addr;
         fifo_data[wr_ptr] <= mem_data;
      end
   end

   // FIFO pointers, occupancy and starvation tracking.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         starve_cnt <= '0;
         force_mem  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         starve_cnt <= starve_next;
         // Raise the flag as soon as the limit is hit so the next cycle belongs to the FIFO.
         force_mem  <= (starve_next == SMAX_C);
      end
   end

   // Registered regfile write port; address/data hold while idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         write_enable <= 1'b0;
         write_addr   <= '0;
         write_data   <= '0;
      end else begin
         case (grant)
            GRANT_ALU: begin
               write_enable <= 1'b1;
               write_addr   <= alu_addr;
               write_data   <= alu_data;
            end
            GRANT_MEM: begin
               write_enable <= 1'b1;
               write_addr   <= fifo_addr[rd_ptr];
               write_data   <= fifo_data[rd_ptr];
            end
            default: write_enable <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized self-checking bench for wb_arbiter against a queue-based reference model
module tb_wb_arbiter;

   localparam int DEPTH = 4;
   localparam int SMAX  = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, alu_ready, mem_valid, mem_ready, write_enable;
   logic [4:0]  alu_addr, mem_addr, write_addr;
   logic [31:0] alu_data, mem_data, write_data;
   logic [2:0]  fifo_count;

   wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   int          streak;
   logic        m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;

   int checks = 0;
   int failures = 0;
   int forced_cycles = 0;
   int peak = 0;
   bit saw_full = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      streak = 0;
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
   endtask

   task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       output logic mem_acc);
      ent_t e;
      logic exp_ar, exp_mr, alu_win, do_push, had;
      alu_valid = av; alu_addr = aa; alu_data = ad;
      mem_valid = mv; mem_addr = ma; mem_data = md;
      #1;
      exp_ar = (streak != SMAX);
      exp_mr = (q.size() < DEPTH);
      check("alu_ready", 32'(alu_ready), 32'(exp_ar));
      check("mem_ready", 32'(mem_ready), 32'(exp_mr));
      check("count_pre", 32'(fifo_count), 32'(q.size()));
      if (alu_ready === 1'b0) forced_cycles++;
      if (mem_ready === 1'b0) saw_full = 1;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      alu_win = av && exp_ar;
      do_push = mv && exp_mr;
      mem_acc = do_push;
`ifdef WB_R0_FILTER_EN
      if (aa == 5'd0) alu_win = 1'b0;
      if (ma == 5'd0) do_push = 1'b0;
`endif
      had  = (q.size() > 0);
      m_we = 1'b0;
      if (streak == SMAX && had) begin
         e = q.pop_front();
         m_we = 1'b1; m_addr = e.a; m_data = e.d;
         streak = 0;
      end else if (alu_win) begin
         m_we = 1'b1; m_addr = aa; m_data = ad;
         streak = had ? ((streak + 1 > SMAX) ? SMAX : streak + 1) : 0;
      end else if (had) begin
         e = q.pop_front();
         m_we = 1'b1; m_addr = e.a; m_data = e.d;
         streak = 0;
      end else begin
         streak = 0;
      end
      if (do_push) q.push_back('{a: ma, d: md});
      @(posedge clk);
      #1;
      check("write_enable", 32'(write_enable), 32'(m_we));
      check("write_addr", 32'(write_addr), 32'(m_addr));
      check("write_data", write_data, m_data);
      check("count_post", 32'(fifo_count), 32'(q.size()));
   endtask

   logic acc;
   int   sent;
   int   fc0;
   int   pa, pm;

   initial begin
      rst = 1'b0;
      alu_valid = 0; alu_addr = 0; alu_data = 0;
      mem_valid = 0; mem_addr = 0; mem_data = 0;
      model_reset();
      #20;
      check("rst_write_enable", 32'(write_enable), 32'd0);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      check("rst_mem_ready", 32'(mem_ready), 32'd1);
      check("rst_alu_ready", 32'(alu_ready), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // single ALU result, then idle
      step(1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 32'd0, acc);
      check("alu_only_data", write_data, 32'hDEADBEEF);
      step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, acc);
      check("alu_only_pulse", 32'(write_enable), 32'd0);

      // mem fill/drain with ALU idle
      peak = 0;
      for (int i = 1; i <= 4; i++)
         step(0, 5'd0, 32'd0, 1, 5'(i), 32'(i * 17), acc);
      for (int i = 0; i < 3; i++)
         step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, acc);
      check("mem_peak_count", 32'(peak), 32'd1);

      // continuous ALU traffic with six mem results: FIFO fills, starvation forces drains
      sent = 0; saw_full = 0; fc0 = forced_cycles;
      for (int c = 0; c < 70; c++) begin
         step(1, 5'(1 + c % 31), $urandom, sent < 6, 5'(10 + sent), 32'(32'h100 + sent), acc);
         if (acc) sent++;
      end
      check("starve_saw_full", 32'(saw_full), 32'd1);
      check("starve_forced", 32'(forced_cycles - fc0), 32'd6);
      check("starve_empty", 32'(fifo_count), 32'd0);

      // asynchronous reset with three entries pending
      for (int i = 0; i < 3; i++)
         step(1, 5'(7 + i), $urandom, 1, 5'(20 + i), $urandom, acc);
      check("pre_reset_count", 32'(fifo_count), 32'd3);
      rst = 1'b0;
      alu_valid = 0; mem_valid = 0;
      #1;
      check("midrst_write_enable", 32'(write_enable), 32'd0);
      check("midrst_fifo_count", 32'(fifo_count), 32'd0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 6; i++)
         step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, acc);

      // register 0 from both sources
      step(1, 5'd0, 32'hA5A5A5A5, 0, 5'd0, 32'd0, acc);
      step(0, 5'd0, 32'd0, 1, 5'd0, 32'h5A5A5A5A, acc);
      for (int i = 0; i < 3; i++)
         step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, acc);

      // randomized traffic at varying densities
      for (int blk = 0; blk < 6; blk++) begin
         pa = $urandom_range(20, 98);
         pm = $urandom_range(20, 90);
         for (int c = 0; c < 100; c++)
            step($urandom_range(0, 99) < pa, 5'($urandom), $urandom,
                 $urandom_range(0, 99) < pm, 5'($urandom), $urandom, acc);
      end
      for (int i = 0; i < 12; i++)
         step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, acc);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
